// File: rtl/spi_device_burst.sv
// SPI slave sampled in the system clock domain. Decodes a command byte into single
// or burst register-bus accesses with address auto-increment; all four CPOL/CPHA modes.
module spi_device_burst #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_sel,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  // The receive register must hold at least the 8-bit command byte.
  localparam int               RX_W      = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int               CNT_W     = $clog2(RX_W + 1);
  localparam logic             SCLK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RFETCH,
    ST_RDATA
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sel_sync_q,  sel_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   settle_q,    settle_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sel_prev_q,  sel_prev_d;
  logic                   armed_q,     armed_d;

  state_e                 state_q,     state_d;
  logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [RX_W-2:0]        rx_q,        rx_d;
  logic [DATA_WIDTH-1:0]  tx_q,        tx_d;
  logic [ADDR_WIDTH-1:0]  reg_addr_q,  reg_addr_d;
  logic [DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic                   reg_wr_q,    reg_wr_d;
  logic                   reg_rd_q,    reg_rd_d;
  logic                   frame_err_q, frame_err_d;

  logic            sclk_s, sel_s, mosi_s;
  logic            sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic            sample_edge, shift_edge;
  logic            sel_fall, sel_rise;
  logic            word_done;
  logic [RX_W-1:0] rx_shift;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sel_s  = sel_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  // A frame may only start from a sel level genuinely seen high after reset, so a
  // sel held low across reset never looks like a falling edge.
  assign sel_fall = armed_q & sel_prev_q & ~sel_s;
  assign sel_rise = sel_s & ~sel_prev_q;

  assign rx_shift = {rx_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], spi_sel};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};
    sclk_prev_d = sclk_s;
    sel_prev_d  = sel_s;
    armed_d     = armed_q | (settle_q[SYNC_STAGES] & sel_s);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    // Post-write increment lands the cycle after the strobe, keeping reg_addr
    // stable while reg_wr is high.
    if (reg_wr_q) reg_addr_d = reg_addr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sel_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (sample_edge) begin
          rx_d      = rx_shift[RX_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CMD_LAST) begin
            word_done  = 1'b1;
            bit_cnt_d  = '0;
            reg_addr_d = rx_shift[6 -: ADDR_WIDTH];
            if (rx_shift[7]) begin
              state_d = ST_WDATA;
            end else begin
              reg_rd_d = 1'b1;
              state_d  = ST_RFETCH;
            end
          end
        end
      end
      ST_WDATA: begin
        if (sample_edge) begin
          rx_d      = rx_shift[RX_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == WORD_LAST) begin
            word_done   = 1'b1;
            bit_cnt_d   = '0;
            reg_wr_d    = 1'b1;
            reg_wdata_d = rx_shift[DATA_WIDTH-1:0];
          end
        end
      end
      ST_RFETCH: begin
        // The responder answers one clk after the strobe, so wait out the strobe cycle.
        if (!reg_rd_q) begin
          tx_d    = reg_rdata;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (sample_edge) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == WORD_LAST) begin
            word_done  = 1'b1;
            bit_cnt_d  = '0;
            reg_addr_d = reg_addr_q + 1'b1;
            reg_rd_d   = 1'b1;
            state_d    = ST_RFETCH;
          end
        end else if (shift_edge && bit_cnt_q != '0) begin
          // The MSB was presented at load time; the shift edge ahead of the first
          // sample of a word must leave it in place.
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over everything except a write word finishing on the same clk.
    if (state_q != ST_IDLE && sel_rise) begin
      frame_err_d = (state_q == ST_CMD && !word_done) ||
                    ((state_q == ST_WDATA || state_q == ST_RDATA) && bit_cnt_d != '0);
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      reg_rd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      sel_sync_q  <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sclk_prev_q <= SCLK_IDLE;
      sel_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sclk_sync_q <= sclk_sync_d;
      sel_sync_q  <= sel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
      sclk_prev_q <= sclk_prev_d;
      sel_prev_q  <= sel_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_oe = ((state_q == ST_RFETCH) || (state_q == ST_RDATA)) && !sel_s;
  assign spi_miso    = spi_miso_oe & tx_q[DATA_WIDTH-1];
  assign reg_addr    = reg_addr_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_rd      = reg_rd_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_device_burst.sv
// Directed bench: one DUT per SPI mode (index = CPOL*2 + CPHA), a bit-banged master,
// a registered read responder and a reg-bus logger.
module tb_spi_device_burst;

  localparam int H = 8;  // spi_clk half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk, sel, mosi;
  logic [3:0] miso, miso_oe, wr, rd, busy, ferr;
  logic [2:0] addr  [4];
  logic [7:0] wdata [4];
  logic [7:0] rdata [4];
  logic [7:0] mem   [4][8];

  logic [2:0] wr_addr_log [4][32];
  logic [7:0] wr_data_log [4][32];
  logic [2:0] rd_log      [4][32];
  int         wr_n [4];
  int         rd_n [4];
  int         err_n [4];

  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_device_burst #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3),
      .CPOL       (g / 2),
      .CPHA       (g % 2),
      .SYNC_STAGES(2)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_clk    (sclk[g]),
      .spi_sel    (sel[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso[g]),
      .spi_miso_oe(miso_oe[g]),
      .reg_addr   (addr[g]),
      .reg_wr     (wr[g]),
      .reg_wdata  (wdata[g]),
      .reg_rd     (rd[g]),
      .reg_rdata  (rdata[g]),
      .busy       (busy[g]),
      .frame_err  (ferr[g])
    );
  end

  // Registered responder: data valid the clk after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) rdata[i] <= mem[i][addr[i]];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr[i]) begin
        if (wr_n[i] < 32) begin
          wr_addr_log[i][wr_n[i]] = addr[i];
          wr_data_log[i][wr_n[i]] = wdata[i];
        end
        wr_n[i]++;
      end
      if (rd[i]) begin
        if (rd_n[i] < 32) rd_log[i][rd_n[i]] = addr[i];
        rd_n[i]++;
      end
      if (ferr[i]) err_n[i]++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits of tx MSB first; samples miso/oe just before each sample edge.
  task automatic xfer(input int m, input logic [31:0] tx, input int nbits,
                      output logic [31:0] rx, output logic [31:0] oe_v);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    rx   = '0;
    oe_v = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (!cpha) begin
        mosi[m] = tx[b];
        wait_clks(H);
        rx[b]   = miso[m];
        oe_v[b] = miso_oe[m];
        sclk[m] = ~cpol;
        wait_clks(H);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = tx[b];
        wait_clks(H);
        rx[b]   = miso[m];
        oe_v[b] = miso_oe[m];
        sclk[m] = cpol;
        wait_clks(H);
      end
    end
  endtask

  task automatic frame(input int m, input logic [31:0] tx, input int nbits,
                       output logic [31:0] rx, output logic [31:0] oe_v);
    sel[m] = 1'b0;
    wait_clks(H);
    xfer(m, tx, nbits, rx, oe_v);
    wait_clks(H);
    sel[m] = 1'b1;
    wait_clks(4 * H);
  endtask

  task automatic test_reset();
    wait_clks(3);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({busy[i], wr[i], rd[i], ferr[i], miso_oe[i], miso[i], addr[i], wdata[i]} !== 17'd0)
        $display("FAIL m%0d reset outputs: got %h expected 0", i,
                 {busy[i], wr[i], rd[i], ferr[i], miso_oe[i], miso[i], addr[i], wdata[i]});
      else n_pass++;
    end
    rst_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_write_single(input int m);
    int w0, e0;
    logic [31:0] rx, oe_v;
    w0 = wr_n[m];
    e0 = err_n[m];
    frame(m, 32'h0000_F06A, 16, rx, oe_v);
    n_total++;
    if (wr_n[m] - w0 !== 1) $display("FAIL m%0d write count: got %0d expected 1", m, wr_n[m] - w0);
    else n_pass++;
    n_total++;
    if (wr_addr_log[m][w0] !== 3'd7) $display("FAIL m%0d write addr: got %0d expected 7", m, wr_addr_log[m][w0]);
    else n_pass++;
    n_total++;
    if (wr_data_log[m][w0] !== 8'h6A) $display("FAIL m%0d write data: got %h expected 6a", m, wr_data_log[m][w0]);
    else n_pass++;
    n_total++;
    if (err_n[m] - e0 !== 0) $display("FAIL m%0d write frame_err: got %0d expected 0", m, err_n[m] - e0);
    else n_pass++;
  endtask

  task automatic test_read_single(input int m);
    int r0, e0, n7;
    logic [31:0] rx, oe_v;
    mem[m][7] = 8'h6A;
    r0 = rd_n[m];
    e0 = err_n[m];
    n7 = 0;
    frame(m, 32'h0000_7000, 16, rx, oe_v);
    for (int k = r0; k < rd_n[m] && k < 32; k++) if (rd_log[m][k] == 3'd7) n7++;
    n_total++;
    if (rx[7:0] !== 8'h6A) $display("FAIL m%0d read miso bits: got %b expected 01101010", m, rx[7:0]);
    else n_pass++;
    n_total++;
    if (oe_v[15:0] !== 16'h00FF) $display("FAIL m%0d miso_oe per bit: got %h expected 00ff", m, oe_v[15:0]);
    else n_pass++;
    n_total++;
    if (rd_log[m][r0] !== 3'd7) $display("FAIL m%0d first read addr: got %0d expected 7", m, rd_log[m][r0]);
    else n_pass++;
    n_total++;
    if (n7 !== 1) $display("FAIL m%0d reads at addr 7: got %0d expected 1", m, n7);
    else n_pass++;
    n_total++;
    if (rd_log[m][r0 + 1] !== 3'd0) $display("FAIL m%0d prefetch addr: got %0d expected 0", m, rd_log[m][r0 + 1]);
    else n_pass++;
    n_total++;
    if ({err_n[m] - e0, miso_oe[m], busy[m]} !== {32'd0, 2'b00})
      $display("FAIL m%0d read end state: got err=%0d oe=%b busy=%b expected 0 0 0", m, err_n[m] - e0, miso_oe[m], busy[m]);
    else n_pass++;
  endtask

  task automatic test_burst();
    int w0, r0;
    logic [31:0] rx, oe_v;
    logic [2:0]  exp_a [3];
    logic [7:0]  exp_d [3];
    exp_a = '{3'd6, 3'd7, 3'd0};
    exp_d = '{8'h11, 8'h22, 8'h33};
    w0 = wr_n[0];
    frame(0, 32'hE011_2233, 32, rx, oe_v);
    n_total++;
    if (wr_n[0] - w0 !== 3) $display("FAIL burst write count: got %0d expected 3", wr_n[0] - w0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({wr_addr_log[0][w0 + k], wr_data_log[0][w0 + k]} !== {exp_a[k], exp_d[k]})
        $display("FAIL burst write %0d: got addr %0d data %h expected addr %0d data %h", k,
                 wr_addr_log[0][w0 + k], wr_data_log[0][w0 + k], exp_a[k], exp_d[k]);
      else n_pass++;
    end
    mem[0][6] = 8'h11;
    mem[0][7] = 8'h22;
    mem[0][0] = 8'h33;
    r0 = rd_n[0];
    frame(0, 32'h6000_0000, 32, rx, oe_v);
    n_total++;
    if (rx[23:0] !== 24'h112233) $display("FAIL burst read miso: got %h expected 112233", rx[23:0]);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd_log[0][r0 + k] !== exp_a[k])
        $display("FAIL burst read addr %0d: got %0d expected %0d", k, rd_log[0][r0 + k], exp_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int w0, e0;
    logic [31:0] rx, oe_v;
    w0 = wr_n[0];
    e0 = err_n[0];
    frame(0, 32'h0000_0A05, 12, rx, oe_v);
    n_total++;
    if (wr_n[0] - w0 !== 0) $display("FAIL abort write count: got %0d expected 0", wr_n[0] - w0);
    else n_pass++;
    n_total++;
    if (err_n[0] - e0 !== 1) $display("FAIL abort frame_err pulses: got %0d expected 1", err_n[0] - e0);
    else n_pass++;
    n_total++;
    if (busy[0] !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy[0]);
    else n_pass++;
    e0 = err_n[0];
    frame(0, 32'h0000_A05A, 16, rx, oe_v);
    n_total++;
    if ({wr_n[0] - w0, wr_addr_log[0][w0], wr_data_log[0][w0]} !== {32'd1, 3'd2, 8'h5A})
      $display("FAIL write after abort: got n=%0d addr %0d data %h expected n=1 addr 2 data 5a",
               wr_n[0] - w0, wr_addr_log[0][w0], wr_data_log[0][w0]);
    else n_pass++;
    n_total++;
    if (err_n[0] - e0 !== 0) $display("FAIL write after abort frame_err: got %0d expected 0", err_n[0] - e0);
    else n_pass++;
  endtask

  task automatic test_read_no_data();
    int r0, e0;
    logic [31:0] rx, oe_v;
    r0 = rd_n[0];
    e0 = err_n[0];
    frame(0, 32'h0000_0040, 8, rx, oe_v);
    n_total++;
    if ({rd_n[0] - r0, rd_log[0][r0]} !== {32'd1, 3'd4})
      $display("FAIL read no data: got n=%0d addr %0d expected n=1 addr 4", rd_n[0] - r0, rd_log[0][r0]);
    else n_pass++;
    n_total++;
    if (err_n[0] - e0 !== 0) $display("FAIL read no data frame_err: got %0d expected 0", err_n[0] - e0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int w0, r0, e0;
    logic [31:0] rx, oe_v;
    w0 = wr_n[0];
    r0 = rd_n[0];
    e0 = err_n[0];
    sel[0] = 1'b0;
    wait_clks(H);
    xfer(0, 32'h0000_0785, 11, rx, oe_v);
    n_total++;
    if (busy[0] !== 1'b1) $display("FAIL busy mid write: got %b expected 1", busy[0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy[0], wr[0], rd[0], ferr[0], miso_oe[0], miso[0], addr[0], wdata[0]} !== 17'd0)
      $display("FAIL outputs in mid-frame reset: got %h expected 0",
               {busy[0], wr[0], rd[0], ferr[0], miso_oe[0], miso[0], addr[0], wdata[0]});
    else n_pass++;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(10);
    xfer(0, 32'h0000_F06A, 16, rx, oe_v);
    wait_clks(H);
    n_total++;
    if ({wr_n[0] - w0, rd_n[0] - r0, busy[0]} !== {32'd0, 32'd0, 1'b0})
      $display("FAIL access with stale sel: got wr=%0d rd=%0d busy=%b expected 0 0 0",
               wr_n[0] - w0, rd_n[0] - r0, busy[0]);
    else n_pass++;
    sel[0] = 1'b1;
    wait_clks(4 * H);
    frame(0, 32'h0000_B0C3, 16, rx, oe_v);
    n_total++;
    if ({wr_n[0] - w0, wr_addr_log[0][w0], wr_data_log[0][w0]} !== {32'd1, 3'd3, 8'hC3})
      $display("FAIL write after reset: got n=%0d addr %0d data %h expected n=1 addr 3 data c3",
               wr_n[0] - w0, wr_addr_log[0][w0], wr_data_log[0][w0]);
    else n_pass++;
    n_total++;
    if (err_n[0] - e0 !== 0) $display("FAIL reset sequence frame_err: got %0d expected 0", err_n[0] - e0);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    sclk    = 4'b1100;
    sel     = 4'b1111;
    mosi    = 4'b0000;
    for (int i = 0; i < 4; i++) for (int a = 0; a < 8; a++) mem[i][a] = 8'h00;

    test_reset();
    for (int m = 0; m < 4; m++) begin
      test_write_single(m);
      test_read_single(m);
    end
    test_burst();
    test_abort();
    test_read_no_data();
    test_reset_mid_frame();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
